// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed common-anode 7-segment scanner
// drives one shared bin-to-seg converter across NDIG digits
module display_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lead,
  output logic [3:0]        conv_bin,
  input  logic [6:0]        conv_seg,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [NDIG-1:0]   an_out,
  output logic              frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] PLAST = CW'(PRESCALE - 1);
  localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [KW-1:0]        k;
  logic [NDIG-1:0][3:0] snap;
  logic [NDIG-1:0]      snap_dp;
  logic [NDIG-1:0]      snap_blk;
  logic [NDIG-1:0]      blk_mask;
  logic                 allz;
  logic                 show_dp;
  logic [NDIG-1:0]      an_sel;

  // leading-zero mask of the live inputs, latched at snapshot time
  always_comb begin
    blk_mask = '0;
    allz     = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      allz        = allz & (digits_in[4*i +: 4] == 4'h0);
      blk_mask[i] = blank_lead & allz;
    end
  end

  // converter input follows the current slot, parked at 0 when idle
  always_comb begin
    conv_bin = (state == IDLE) ? 4'h0 : snap[k];
    show_dp  = snap_dp[k] & ~snap_blk[k];
    an_sel   = snap_blk[k] ? '1 : ~(NDIG'(1) << k);
  end

  // scan FSM: blank guard, show phase, slot and frame sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      k          <= '0;
      snap       <= '0;
      snap_dp    <= '0;
      snap_blk   <= '0;
      an_out     <= '1;
      seg_out    <= '0;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            snap     <= digits_in;
            snap_dp  <= dp_in;
            snap_blk <= blk_mask;
            k        <= '0;
            cnt      <= '0;
            state    <= BLANK;
          end
        end
        BLANK: begin
          cnt     <= cnt + 1'b1;
          seg_out <= conv_seg;
          dp_out  <= show_dp;
          if (cnt == BLAST) begin
            state  <= SHOW;
            an_out <= an_sel;
          end
        end
        SHOW: begin
          seg_out <= conv_seg;
          dp_out  <= show_dp;
          if (cnt == PLAST) begin
            cnt    <= '0;
            an_out <= '1;
            if (k != KLAST) begin
              if (en) begin
                k     <= k + 1'b1;
                state <= BLANK;
              end else begin
                k       <= '0;
                seg_out <= '0;
                dp_out  <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              frame_done <= 1'b1;
              k          <= '0;
              if (en) begin
                snap     <= digits_in;
                snap_dp  <= dp_in;
                snap_blk <= blk_mask;
                state    <= BLANK;
              end else begin
                seg_out <= '0;
                dp_out  <= 1'b0;
                state   <= IDLE;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          an_out <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table-driven scan frames with slot scoreboard
// includes a behavioural bin-to-seg converter on conv_bin/conv_seg
module tb_display_scan_ctrl;

  localparam int NDIG = 4;
  localparam int PRE  = 8;
  localparam int BLK  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lead;
  logic [3:0]  conv_bin;
  logic [6:0]  conv_seg;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic        bl;
    logic [3:0]  lit;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] bin;
    logic       lit;
  } slot_t;

  slot_t      sb[$];
  vec_t       vt[5];
  logic [3:0] an_ord[4];

  display_scan_ctrl #(
    .NDIG(NDIG),
    .PRESCALE(PRE),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .digits_in(digits_in),
    .dp_in(dp_in),
    .blank_lead(blank_lead),
    .conv_bin(conv_bin),
    .conv_seg(conv_seg),
    .seg_out(seg_out),
    .dp_out(dp_out),
    .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] b);
    case (b)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_comb conv_seg = seg7(conv_bin);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input vec_t v, input int n);
    slot_t s;
    for (int j = 0; j < n; j++) begin
      s.bin = v.dig[4*j +: 4];
      s.lit = v.lit[j];
      s.an  = s.lit ? an_ord[j] : 4'hF;
      s.seg = seg7(s.bin);
      s.dp  = v.dp[j] & v.lit[j];
      sb.push_back(s);
    end
  endtask

  task automatic start_frame(input vec_t v, input int n);
    digits_in  = v.dig;
    dp_in      = v.dp;
    blank_lead = v.bl;
    en         = 1'b1;
    push_frame(v, n);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_an"}, an_out, 4'hF);
    chk({nm, "_seg"}, seg_out, 7'h00);
    chk({nm, "_dp"}, dp_out, 1'b0);
    chk({nm, "_bin"}, conv_bin, 4'h0);
  endtask

  task automatic check_frame(input int n, input int chg_c,
                             input logic [15:0] chg_v,
                             input int drop_c);
    slot_t s;
    int    ph;
    s.an  = 4'hF;
    s.seg = 7'h00;
    s.dp  = 1'b0;
    s.bin = 4'h0;
    s.lit = 1'b0;
    for (int c = 0; c < n * PRE; c++) begin
      ph = c % PRE;
      if (ph == 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: empty at cycle %0d", c);
        end else begin
          s = sb.pop_front();
        end
      end
      chk("conv_bin", conv_bin, s.bin);
      if (ph < BLK) begin
        chk("an_guard", an_out, 4'hF);
      end else begin
        chk("an_show", an_out, s.an);
        chk("dp_show", dp_out, s.dp);
        if (s.lit) chk("seg_show", seg_out, s.seg);
      end
      if (c > 0) chk("fd_mid", frame_done, 1'b0);
      if (c == chg_c) digits_in = chg_v;
      if (c == drop_c) en = 1'b0;
      @(posedge clk);
      #1;
    end
    if (n == NDIG) chk("fd_pulse", frame_done, 1'b1);
    else chk("fd_none", frame_done, 1'b0);
    if (!en) begin
      check_idle("idle_after");
      @(posedge clk);
      #1;
      chk("fd_clear", frame_done, 1'b0);
    end
  endtask

  initial begin
    vec_t v;
    an_ord = '{4'hE, 4'hD, 4'hB, 4'h7};
    vt[0] = '{dig: 16'h4321, dp: 4'h0, bl: 1'b0, lit: 4'hF};
    vt[1] = '{dig: 16'h0070, dp: 4'h0, bl: 1'b1, lit: 4'h3};
    vt[2] = '{dig: 16'h0000, dp: 4'h0, bl: 1'b1, lit: 4'h1};
    vt[3] = '{dig: 16'h0105, dp: 4'hF, bl: 1'b1, lit: 4'h7};
    vt[4] = '{dig: 16'hABCD, dp: 4'h5, bl: 1'b0, lit: 4'hF};

    rst_n      = 1'b0;
    en         = 1'b0;
    digits_in  = 16'h0;
    dp_in      = 4'h0;
    blank_lead = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_fd", frame_done, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_an", an_out, 4'hF);
      chk("idle_seg", seg_out, 7'h00);
      chk("idle_fd", frame_done, 1'b0);
    end

    for (int i = 0; i < 5; i++) begin
      start_frame(vt[i], NDIG);
      check_frame(NDIG, -1, 16'h0, 3 * PRE + 4);
    end

    v = '{dig: 16'h1111, dp: 4'h0, bl: 1'b0, lit: 4'hF};
    start_frame(v, NDIG);
    check_frame(NDIG, PRE + 2, 16'h9999, -1);
    v = '{dig: 16'h9999, dp: 4'h0, bl: 1'b0, lit: 4'hF};
    push_frame(v, NDIG);
    check_frame(NDIG, -1, 16'h0, 3 * PRE + 4);

    v = vt[0];
    start_frame(v, 3);
    check_frame(3, -1, 16'h0, 2 * PRE + 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("drop_fd", frame_done, 1'b0);
      chk("drop_an", an_out, 4'hF);
    end
    start_frame(v, NDIG);
    check_frame(NDIG, -1, 16'h0, 3 * PRE + 4);

    digits_in  = v.dig;
    dp_in      = v.dp;
    blank_lead = v.bl;
    en         = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_an", an_out, 4'hE);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_fd", frame_done, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_frame(v, NDIG);
    check_frame(NDIG, -1, 16'h0, 3 * PRE + 4);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d slots left", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
